// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared classifier constants and argmax state type
package mnist_pkg;

  localparam int DATA_WIDTH  = 6;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_WIDTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } argmax_state_e;

endpackage

// File: rtl/argmax_fix6_if.sv
// rtl/argmax_fix6_if.sv - engine/consumer bundle around the argmax block
//
// Signals:
//   start      engine done pulse, launches a scan
//   score_idx  class index presented to the engine output selector
//   score      engine score for score_idx, valid in the same cycle
//   busy       high while scanning
//   res_valid  result available
//   res_ready  consumer accepts the result
//   digit      winning class index
//   max_score  winning score
//   tie        another class matched max_score
//   overrun    one-cycle pulse when a start is dropped
// Modports: slave = argmax block, master = engine/consumer side.
interface argmax_fix6_if
  import mnist_pkg::*;
#(
  parameter int DATA_WIDTH = mnist_pkg::DATA_WIDTH
);

  logic                         start;
  logic [IDX_WIDTH-1:0]         score_idx;
  logic signed [DATA_WIDTH-1:0] score;
  logic                         busy;
  logic                         res_valid;
  logic                         res_ready;
  logic [IDX_WIDTH-1:0]         digit;
  logic signed [DATA_WIDTH-1:0] max_score;
  logic                         tie;
  logic                         overrun;

  modport slave (
    input  start, score, res_ready,
    output score_idx, busy, res_valid, digit, max_score, tie, overrun
  );

  modport master (
    output start, score, res_ready,
    input  score_idx, busy, res_valid, digit, max_score, tie, overrun
  );

endinterface

// File: rtl/argmax_fix6.sv
// rtl/argmax_fix6.sv - sequential argmax over the engine class scores
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  argmax_fix6_if.slave (start/score in, index/result/status out)
//
// A start in IDLE scans classes 0..NUM_CLASSES-1, one per cycle, driving
// score_idx and sampling score combinationally. The result is latched on
// entry to HOLD and held until res_valid/res_ready handshake.
module argmax_fix6
  import mnist_pkg::*;
#(
  parameter int DATA_WIDTH  = mnist_pkg::DATA_WIDTH,
  parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES
) (
  input  logic          clk,
  input  logic          rst,
  argmax_fix6_if.slave  bus
);

  localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(NUM_CLASSES - 1);

  argmax_state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]         k_q;
  logic signed [DATA_WIDTH-1:0] best_q;
  logic [IDX_WIDTH-1:0]         best_idx_q;
  logic                         tie_q;

  logic [IDX_WIDTH-1:0]         digit_q;
  logic signed [DATA_WIDTH-1:0] max_q;
  logic                         res_tie_q;
  logic                         overrun_q;

  logic signed [DATA_WIDTH-1:0] cand_best;
  logic [IDX_WIDTH-1:0]         cand_idx;
  logic                         cand_tie;
  logic                         last_k;

  assign last_k = (k_q == K_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start)     state_d = ST_SCAN;
      ST_SCAN: if (last_k)        state_d = ST_HOLD;
      ST_HOLD: if (bus.res_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Running compare; equal scores only flag a tie so the lowest index wins.
  always_comb begin
    cand_best = best_q;
    cand_idx  = best_idx_q;
    cand_tie  = tie_q;
    if (k_q == '0) begin
      cand_best = bus.score;
      cand_idx  = '0;
      cand_tie  = 1'b0;
    end else if (bus.score > best_q) begin
      cand_best = bus.score;
      cand_idx  = k_q;
      cand_tie  = 1'b0;
    end else if (bus.score == best_q) begin
      cand_tie  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      tie_q      <= 1'b0;
      digit_q    <= '0;
      max_q      <= '0;
      res_tie_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Any start outside IDLE is dropped, including one coinciding with the handshake.
      overrun_q <= bus.start && (state_q != ST_IDLE);
      if (state_q == ST_SCAN) begin
        best_q     <= cand_best;
        best_idx_q <= cand_idx;
        tie_q      <= cand_tie;
        if (last_k) begin
          k_q       <= '0;
          digit_q   <= cand_idx;
          max_q     <= cand_best;
          res_tie_q <= cand_tie;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end else begin
        k_q <= '0;
      end
    end
  end

  assign bus.score_idx = (state_q == ST_SCAN) ? k_q : '0;
  assign bus.busy      = (state_q == ST_SCAN);
  assign bus.res_valid = (state_q == ST_HOLD);
  assign bus.digit     = digit_q;
  assign bus.max_score = max_q;
  assign bus.tie       = res_tie_q;
  assign bus.overrun   = overrun_q;

endmodule
